// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Two-master, one-slave arbiter for the PicoRV32 native memory bus.
// Master 0 is normally the CPU, master 1 a debug loader or second core.
// Round-robin between masters, grant locked for a whole transaction, one
// dead GAP cycle after every transaction, and a watchdog that completes a
// transaction with ERR_RDATA when the slave never answers.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   m0_* / m1_*                master-side native bus (valid/addr/wdata/wstrb
//                              in, rdata/ready out)
//   s_*                        slave-side native bus towards the memory
//                              controller (valid/addr/wdata/wstrb out,
//                              rdata/ready in)
//   grant                      one-hot current owner, 2'b00 when nobody owns
//   timeout_err / timeout_clr  sticky watchdog flag and its synchronous clear

module mem_bus_arbiter #(
  parameter int          TIMEOUT   = 1024,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,

  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,

  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,

  output logic [1:0]  grant,
  output logic        timeout_err,
  input  logic        timeout_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Last watchdog value; the counter saturates here instead of wrapping.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  grant_q;
  logic        rr_ptr;
  logic [15:0] wd_cnt;
  logic        timeout_err_q;

  logic        busy;
  logic        sel_valid;
  logic        wd_expired;
  logic        done_ok;
  logic        done_to;
  logic        done;
  logic [31:0] done_rdata;

  assign busy       = (state == BUSY);
  assign sel_valid  = (grant_q[0] & m0_valid) | (grant_q[1] & m1_valid);
  assign wd_expired = (wd_cnt == WD_LAST);

  // A real s_ready always beats the watchdog, even on its final cycle.
  // A master that has dropped valid has aborted, so a late s_ready is ignored.
  assign done_ok    = busy & sel_valid & s_ready;
  assign done_to    = busy & sel_valid & ~s_ready & wd_expired;
  assign done       = done_ok | done_to;
  assign done_rdata = s_ready ? s_rdata : ERR_RDATA;

  // grant_q is only non-zero in BUSY, so it alone gates the slave-side mux
  // and every output collapses to zero in IDLE, GAP and reset.
  assign s_valid = busy & sel_valid;
  assign s_addr  = ({32{grant_q[0]}} & m0_addr)  | ({32{grant_q[1]}} & m1_addr);
  assign s_wdata = ({32{grant_q[0]}} & m0_wdata) | ({32{grant_q[1]}} & m1_wdata);
  assign s_wstrb = ({4{grant_q[0]}}  & m0_wstrb) | ({4{grant_q[1]}}  & m1_wstrb);

  assign m0_ready = done & grant_q[0];
  assign m1_ready = done & grant_q[1];
  assign m0_rdata = m0_ready ? done_rdata : 32'h0;
  assign m1_rdata = m1_ready ? done_rdata : 32'h0;

  assign grant       = grant_q;
  assign timeout_err = timeout_err_q;

  // Arbitration FSM. rr_ptr names the master preferred on the next tie and
  // only moves when a transaction really completes (normally or by timeout);
  // an abort leaves the preference where it was.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= 2'b00;
      rr_ptr  <= 1'b0;
      wd_cnt  <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid && (!m1_valid || !rr_ptr)) begin
            grant_q <= 2'b01;
            wd_cnt  <= 16'h0;
            state   <= BUSY;
          end else if (m1_valid) begin
            grant_q <= 2'b10;
            wd_cnt  <= 16'h0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!sel_valid) begin
            grant_q <= 2'b00;
            state   <= GAP;
          end else if (done) begin
            rr_ptr  <= grant_q[0];
            grant_q <= 2'b00;
            state   <= GAP;
          end else if (!wd_expired) begin
            wd_cnt <= wd_cnt + 16'h1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          grant_q <= 2'b00;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Sticky watchdog flag; a timeout in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err_q <= 1'b0;
    end else if (done_to) begin
      timeout_err_q <= 1'b1;
    end else if (timeout_clr) begin
      timeout_err_q <= 1'b0;
    end
  end

endmodule
